// File: rtl/pw_cache_pkg.sv
// Shared widths, FSM state encoding and entry layout for the page-walk cache.
package pwu_pkg;

    localparam int KEY_W     = 16;
    localparam int IDX_W_DEF = 4;
    localparam int TAG_W_MAX = KEY_W - 1;
    localparam int DATA_W    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } pw_c_state_e;

    // Tag field is sized for the smallest legal index so any IDX_W fits;
    // the unused upper bits stay zero.
    typedef struct packed {
        logic                 valid;
        logic [TAG_W_MAX-1:0] tag;
        logic [DATA_W-1:0]    data;
    } pw_c_entry_t;

    function automatic logic [TAG_W_MAX-1:0] tag_of(input logic [KEY_W-1:0] key,
                                                    input int unsigned      idx_w);
        logic [KEY_W-1:0] shifted;
        shifted = key >> idx_w;
        return shifted[TAG_W_MAX-1:0];
    endfunction

endpackage

// File: rtl/pw_cache_sat_cnt16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_cnt16 (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        inc_i,
    output logic [15:0] cnt_o
);

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != 16'hFFFF)) begin
            cnt_o <= cnt_o + 16'd1;
        end
    end

endmodule

// File: rtl/pw_cache.sv
// Direct-mapped page-walk cache: registered lookup, stalling refill over a
// valid/ready port, single-cycle flush and saturating hit/miss counters.
module pw_cache
    import pwu_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic [31:0] pw_c_va_i,
    input  logic        pw_c_vld_i,
    output logic [15:0] pw_c_pa_o,
    output logic        pw_c_stall_o,
    output logic [15:0] rf_req_key_o,
    output logic        rf_req_vld_o,
    input  logic        rf_req_rdy_i,
    input  logic [15:0] rf_rsp_pa_i,
    input  logic        rf_rsp_vld_i,
    input  logic        flush_i,
    output logic [15:0] hit_cnt_o,
    output logic [15:0] miss_cnt_o
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [KEY_W-1:0] key;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] refill_idx;
    logic [15:0]      unused_va_bits;

    pw_c_entry_t entries [ENTRIES];
    pw_c_state_e state, state_nxt;

    logic [KEY_W-1:0] key_q;
    logic [15:0]      pa_q;
    logic             stale_q;

    logic lookup_hit;
    logic hit_evt;
    logic miss_evt;
    logic install;
    logic req_vld;
    logic stall;

    assign key            = pw_c_va_i[31:16];
    assign unused_va_bits = pw_c_va_i[15:0];
    assign idx            = key[IDX_W-1:0];
    assign refill_idx     = key_q[IDX_W-1:0];
    assign lookup_hit     = entries[idx].valid && (entries[idx].tag == tag_of(key, IDX_W));

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A flush coinciding with a lookup forces the miss path so no data
    // from an entry being invalidated this edge is ever returned.
    always_comb begin
        state_nxt = state;
        hit_evt   = 1'b0;
        miss_evt  = 1'b0;
        install   = 1'b0;
        req_vld   = 1'b0;
        stall     = 1'b0;
        unique case (state)
            IDLE: begin
                if (pw_c_vld_i) begin
                    if (lookup_hit && !flush_i) begin
                        hit_evt = 1'b1;
                    end else begin
                        miss_evt  = 1'b1;
                        stall     = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                req_vld = 1'b1;
                stall   = 1'b1;
                if (rf_req_rdy_i) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (rf_rsp_vld_i) begin
                    install   = !(stale_q || flush_i);
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            key_q   <= '0;
            pa_q    <= '0;
            stale_q <= 1'b0;
        end else begin
            if (miss_evt) begin
                key_q <= key;
            end
            if (hit_evt) begin
                pa_q <= entries[idx].data;
            end
            if ((state == WAIT) && rf_rsp_vld_i) begin
                stale_q <= 1'b0;
            end else if ((state != IDLE) && flush_i) begin
                stale_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries[i] <= '0;
            end
        end else if (flush_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else if (install) begin
            entries[refill_idx].valid <= 1'b1;
            entries[refill_idx].tag   <= tag_of(key_q, IDX_W);
            entries[refill_idx].data  <= rf_rsp_pa_i;
        end
    end

    sat_cnt16 u_hit_cnt (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .inc_i    (hit_evt),
        .cnt_o    (hit_cnt_o)
    );

    sat_cnt16 u_miss_cnt (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .inc_i    (miss_evt),
        .cnt_o    (miss_cnt_o)
    );

    assign pw_c_pa_o    = pa_q;
    assign pw_c_stall_o = stall;
    assign rf_req_key_o = key_q;
    assign rf_req_vld_o = req_vld;

endmodule

// File: tb/tb_pw_cache.sv
// Directed bench for pw_cache: cold miss, repeat hit, conflict eviction,
// refill backpressure, flush during refill and reset during refill.
module tb_pw_cache;

    logic        clk_i;
    logic        resetn_i;
    logic [31:0] pw_c_va_i;
    logic        pw_c_vld_i;
    logic [15:0] pw_c_pa_o;
    logic        pw_c_stall_o;
    logic [15:0] rf_req_key_o;
    logic        rf_req_vld_o;
    logic        rf_req_rdy_i;
    logic [15:0] rf_rsp_pa_i;
    logic        rf_rsp_vld_i;
    logic        flush_i;
    logic [15:0] hit_cnt_o;
    logic [15:0] miss_cnt_o;

    int total;
    int bad;

    pw_cache #(.IDX_W(4)) dut (
        .clk_i        (clk_i),
        .resetn_i     (resetn_i),
        .pw_c_va_i    (pw_c_va_i),
        .pw_c_vld_i   (pw_c_vld_i),
        .pw_c_pa_o    (pw_c_pa_o),
        .pw_c_stall_o (pw_c_stall_o),
        .rf_req_key_o (rf_req_key_o),
        .rf_req_vld_o (rf_req_vld_o),
        .rf_req_rdy_i (rf_req_rdy_i),
        .rf_rsp_pa_i  (rf_rsp_pa_i),
        .rf_rsp_vld_i (rf_rsp_vld_i),
        .flush_i      (flush_i),
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] va, input logic vld,
                                 input logic flush, input logic rdy);
        pw_c_va_i    = va;
        pw_c_vld_i   = vld;
        flush_i      = flush;
        rf_req_rdy_i = rdy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drives one refill response after the request has been accepted.
    task automatic respond(input logic [15:0] pa);
        rf_rsp_pa_i  = pa;
        rf_rsp_vld_i = 1'b1;
        tick();
        rf_rsp_vld_i = 1'b0;
        #1;
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        resetn_i     = 1'b0;
        rf_rsp_pa_i  = '0;
        rf_rsp_vld_i = 1'b0;
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("rst_pa", pw_c_pa_o, 16'h0);
        checkOutput("rst_stall", {15'd0, pw_c_stall_o}, 16'h0);
        checkOutput("rst_key", rf_req_key_o, 16'h0);
        checkOutput("rst_req_vld", {15'd0, rf_req_vld_o}, 16'h0);
        checkOutput("rst_hit", hit_cnt_o, 16'h0);
        checkOutput("rst_miss", miss_cnt_o, 16'h0);
        resetn_i = 1'b1;
        tick();

        $display("[TB] cold miss");
        applyStimulus(32'h1234_5000, 1'b1, 1'b0, 1'b1);
        checkOutput("cold_stall_idle", {15'd0, pw_c_stall_o}, 16'h1);
        tick();
        checkOutput("cold_req_vld", {15'd0, rf_req_vld_o}, 16'h1);
        checkOutput("cold_req_key", rf_req_key_o, 16'h1234);
        checkOutput("cold_stall_req", {15'd0, pw_c_stall_o}, 16'h1);
        checkOutput("cold_miss_cnt", miss_cnt_o, 16'd1);
        tick();
        checkOutput("cold_req_done", {15'd0, rf_req_vld_o}, 16'h0);
        checkOutput("cold_stall_wait", {15'd0, pw_c_stall_o}, 16'h1);
        tick();
        respond(16'hABCD);
        checkOutput("cold_replay_stall", {15'd0, pw_c_stall_o}, 16'h0);
        tick();
        applyStimulus(32'h1234_5000, 1'b0, 1'b0, 1'b1);
        checkOutput("cold_pa", pw_c_pa_o, 16'hABCD);
        checkOutput("cold_hit_cnt", hit_cnt_o, 16'd1);
        checkOutput("cold_miss_cnt2", miss_cnt_o, 16'd1);

        $display("[TB] repeat hit");
        applyStimulus(32'h1234_FFFF, 1'b1, 1'b0, 1'b1);
        checkOutput("rep_stall", {15'd0, pw_c_stall_o}, 16'h0);
        tick();
        applyStimulus(32'h1234_FFFF, 1'b0, 1'b0, 1'b1);
        checkOutput("rep_pa", pw_c_pa_o, 16'hABCD);
        checkOutput("rep_hit_cnt", hit_cnt_o, 16'd2);

        $display("[TB] conflict eviction");
        applyStimulus(32'h5674_0000, 1'b1, 1'b0, 1'b1);
        checkOutput("cf1_stall", {15'd0, pw_c_stall_o}, 16'h1);
        tick();
        checkOutput("cf1_key", rf_req_key_o, 16'h5674);
        tick();
        respond(16'h5678);
        tick();
        applyStimulus(32'h1234_0000, 1'b1, 1'b0, 1'b1);
        checkOutput("cf1_pa", pw_c_pa_o, 16'h5678);
        checkOutput("cf2_stall", {15'd0, pw_c_stall_o}, 16'h1);
        tick();
        checkOutput("cf2_key", rf_req_key_o, 16'h1234);
        tick();
        respond(16'hABCE);
        tick();
        applyStimulus(32'h1234_0000, 1'b0, 1'b0, 1'b1);
        checkOutput("cf2_pa", pw_c_pa_o, 16'hABCE);
        checkOutput("cf2_miss_cnt", miss_cnt_o, 16'd3);
        checkOutput("cf2_hit_cnt", hit_cnt_o, 16'd4);

        $display("[TB] refill backpressure");
        applyStimulus(32'h9ABC_0000, 1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_req_vld", {15'd0, rf_req_vld_o}, 16'h1);
            checkOutput("bp_key", rf_req_key_o, 16'h9ABC);
            checkOutput("bp_stall", {15'd0, pw_c_stall_o}, 16'h1);
            tick();
        end
        applyStimulus(32'h9ABC_0000, 1'b1, 1'b0, 1'b1);
        checkOutput("bp_req_last", {15'd0, rf_req_vld_o}, 16'h1);
        tick();
        checkOutput("bp_req_done", {15'd0, rf_req_vld_o}, 16'h0);
        respond(16'h2222);
        tick();
        applyStimulus(32'h9ABC_0000, 1'b0, 1'b0, 1'b1);
        checkOutput("bp_pa", pw_c_pa_o, 16'h2222);
        checkOutput("bp_miss_cnt", miss_cnt_o, 16'd4);

        $display("[TB] flush during refill");
        applyStimulus(32'h0F0F_0000, 1'b1, 1'b0, 1'b1);
        tick();
        tick();
        applyStimulus(32'h0F0F_0000, 1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(32'h0F0F_0000, 1'b1, 1'b0, 1'b1);
        respond(16'h1111);
        checkOutput("fl_replay_stall", {15'd0, pw_c_stall_o}, 16'h1);
        tick();
        checkOutput("fl_req_again", {15'd0, rf_req_vld_o}, 16'h1);
        checkOutput("fl_key_again", rf_req_key_o, 16'h0F0F);
        checkOutput("fl_miss_cnt", miss_cnt_o, 16'd6);
        tick();
        respond(16'h3333);
        tick();
        applyStimulus(32'h0F0F_0000, 1'b0, 1'b0, 1'b1);
        checkOutput("fl_pa", pw_c_pa_o, 16'h3333);
        checkOutput("fl_hit_cnt", hit_cnt_o, 16'd6);

        $display("[TB] flush with lookup in idle");
        applyStimulus(32'h0F0F_0000, 1'b1, 1'b1, 1'b1);
        checkOutput("fi_stall", {15'd0, pw_c_stall_o}, 16'h1);
        tick();
        applyStimulus(32'h0F0F_0000, 1'b1, 1'b0, 1'b1);
        checkOutput("fi_miss_cnt", miss_cnt_o, 16'd7);
        checkOutput("fi_hit_cnt", hit_cnt_o, 16'd6);
        checkOutput("fi_pa_hold", pw_c_pa_o, 16'h3333);
        tick();
        respond(16'h4444);
        tick();
        applyStimulus(32'h0F0F_0000, 1'b0, 1'b0, 1'b1);
        checkOutput("fi_pa", pw_c_pa_o, 16'h4444);

        $display("[TB] reset during refill");
        applyStimulus(32'h1234_5000, 1'b1, 1'b0, 1'b1);
        tick();
        tick();
        applyStimulus(32'h1234_5000, 1'b0, 1'b0, 1'b1);
        resetn_i = 1'b0;
        #1;
        checkOutput("rw_pa", pw_c_pa_o, 16'h0);
        checkOutput("rw_stall", {15'd0, pw_c_stall_o}, 16'h0);
        checkOutput("rw_key", rf_req_key_o, 16'h0);
        checkOutput("rw_req_vld", {15'd0, rf_req_vld_o}, 16'h0);
        checkOutput("rw_hit", hit_cnt_o, 16'h0);
        checkOutput("rw_miss", miss_cnt_o, 16'h0);
        resetn_i = 1'b1;
        #1;
        respond(16'h7777);
        checkOutput("rw_late_rsp_idle", {15'd0, pw_c_stall_o}, 16'h0);
        applyStimulus(32'h1234_5000, 1'b1, 1'b0, 1'b1);
        checkOutput("rw_lookup_stall", {15'd0, pw_c_stall_o}, 16'h1);
        tick();
        checkOutput("rw_lookup_req", {15'd0, rf_req_vld_o}, 16'h1);
        checkOutput("rw_lookup_miss", miss_cnt_o, 16'd1);
        checkOutput("rw_lookup_pa", pw_c_pa_o, 16'h0);
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        respond(16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
